// File: rtl/spi_command_pkg.sv
// Shared constants, state encoding and helpers for the SPI command engine.
package spi_command_pkg;

  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_WRITE = 4'h3;
  localparam logic [3:0] OP_TX    = 4'h4;
  localparam logic [3:0] OP_RX    = 4'h5;
  localparam logic [3:0] OP_RST   = 4'hF;

  typedef enum logic [3:0] {
    StIdle,
    StRd1,
    StRd2,
    StWr1,
    StWr2,
    StTx1,
    StTx2,
    StTx3,
    StRx1,
    StRx2,
    StRx3,
    StRx4,
    StRst
  } state_e;

  localparam logic [7:0] RESP_TX_FULL      = 8'h81;
  localparam logic [7:0] RESP_TX_NOT_READY = 8'h82;
  localparam logic [7:0] RESP_BAD_CHANNEL  = 8'h83;

  localparam int unsigned STAT_RX_ERROR    = 6;
  localparam int unsigned STAT_RX_ACTIVE   = 5;
  localparam int unsigned STAT_TX_COMPLETE = 3;
  localparam int unsigned STAT_TX_ACTIVE   = 2;

  localparam logic [3:0] REG_ID      = 4'hF;
  localparam logic [3:0] STATUS_BASE = 4'h8;

  function automatic logic [7:0] status_byte(input logic rx_error, input logic rx_active,
                                             input logic tx_complete, input logic tx_active);
    logic [7:0] b;
    b                   = 8'h00;
    b[STAT_RX_ERROR]    = rx_error;
    b[STAT_RX_ACTIVE]   = rx_active;
    b[STAT_TX_COMPLETE] = tx_complete;
    b[STAT_TX_ACTIVE]   = tx_active;
    return b;
  endfunction

endpackage

// File: rtl/spi_command_engine_channel_status.sv
// Per-channel tx_active falling-edge detector with a sticky tx_complete flag.
module channel_status (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tx_active_i,
  input  logic clear_i,
  output logic tx_complete_o
);

  logic active_q;
  logic complete_q, complete_d;
  logic set;

  assign set = active_q & ~tx_active_i;

  // Set has priority over a same-cycle clear.
  always_comb begin
    complete_d = complete_q;
    if (clear_i) complete_d = 1'b0;
    if (set)     complete_d = 1'b1;
  end

  // Edge-detect history and sticky flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active_q   <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      active_q   <= tx_active_i;
      complete_q <= complete_d;
    end
  end

  assign tx_complete_o = complete_q;

endmodule

// File: rtl/spi_command_engine.sv
// Decodes SPI command bytes into register accesses and per-channel TX/RX word transfers.
module spi_command_engine
  import spi_command_pkg::*;
#(
  parameter int unsigned           NUM_CHANNELS = 2,
  parameter int unsigned           WORD_WIDTH   = 10,
  parameter int unsigned           NUM_REGS     = 2,
  parameter logic [8*NUM_REGS-1:0] DEFAULT_REGS = {8'b01001000, 8'b01001000},
  parameter logic [7:0]            ID_VALUE     = 8'ha5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             spi_cs_n,
  input  logic [7:0]                       spi_rx_data,
  input  logic                             spi_rx_strobe,
  output logic [7:0]                       spi_tx_data,
  output logic                             spi_tx_strobe,
  output logic [8*NUM_REGS-1:0]            control_regs,
  output logic [NUM_CHANNELS-1:0]          tx_reset,
  output logic [WORD_WIDTH-1:0]            tx_data,
  output logic [NUM_CHANNELS-1:0]          tx_load_strobe,
  output logic [NUM_CHANNELS-1:0]          tx_start_strobe,
  input  logic [NUM_CHANNELS-1:0]          tx_active,
  input  logic [NUM_CHANNELS-1:0]          tx_empty,
  input  logic [NUM_CHANNELS-1:0]          tx_full,
  input  logic [NUM_CHANNELS-1:0]          tx_ready,
  output logic [NUM_CHANNELS-1:0]          rx_reset,
  output logic [NUM_CHANNELS-1:0]          rx_read_strobe,
  input  logic [WORD_WIDTH*NUM_CHANNELS-1:0] rx_data,
  input  logic [NUM_CHANNELS-1:0]          rx_active,
  input  logic [NUM_CHANNELS-1:0]          rx_error,
  input  logic [NUM_CHANNELS-1:0]          rx_empty
);

  localparam int unsigned HiW = WORD_WIDTH - 8;

  logic                    cs_meta_q, cs_sync_q;
  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [7:0]              mask_q, mask_d;
  logic [HiW-1:0]          hi_q, hi_d;
  logic                    word_valid_q, word_valid_d;
  logic [15:0]             snap_q, snap_d;
  logic [7:0]              spi_tx_data_q, spi_tx_data_d;
  logic                    spi_tx_strobe_q, spi_tx_strobe_d;
  logic [8*NUM_REGS-1:0]   control_regs_q, control_regs_d;
  logic [WORD_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [NUM_CHANNELS-1:0] tx_load_q, tx_load_d, tx_start_q, tx_start_d;
  logic [NUM_CHANNELS-1:0] tx_reset_q, tx_reset_d, rx_reset_q, rx_reset_d;
  logic [NUM_CHANNELS-1:0] rx_read_q, rx_read_d;
  logic [NUM_CHANNELS-1:0] tx_complete, tx_clear, chan_oh;

  logic                  chan_valid, reg_valid, stat_valid;
  logic                  sel_full, sel_ready, sel_rx_error, sel_rx_empty;
  logic [WORD_WIDTH-1:0] sel_rx_data;
  logic [7:0]            sel_reg, stat_byte, read_byte;
  logic [15:0]           rx_word;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    channel_status u_status (
      .clk_i         (clk),
      .reset_i       (reset),
      .tx_active_i   (tx_active[c]),
      .clear_i       (tx_clear[c]),
      .tx_complete_o (tx_complete[c])
    );
  end

  // Select channel, register and status sources addressed by the latched index.
  always_comb begin
    chan_oh      = '0;
    sel_full     = 1'b0;
    sel_ready    = 1'b0;
    sel_rx_error = 1'b0;
    sel_rx_empty = 1'b0;
    sel_rx_data  = '0;
    stat_valid   = 1'b0;
    stat_byte    = 8'h00;
    sel_reg      = 8'h00;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (32'(idx_q) == c) begin
        chan_oh[c]   = 1'b1;
        sel_full     = tx_full[c];
        sel_ready    = tx_ready[c];
        sel_rx_error = rx_error[c];
        sel_rx_empty = rx_empty[c];
        sel_rx_data  = rx_data[c*WORD_WIDTH +: WORD_WIDTH];
      end
      if (32'(idx_q) == 32'(STATUS_BASE) + c) begin
        stat_valid = 1'b1;
        stat_byte  = status_byte(rx_error[c], rx_active[c], tx_complete[c], tx_active[c]);
      end
    end
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (32'(idx_q) == r) sel_reg = control_regs_q[8*r +: 8];
    end
  end

  assign chan_valid = |chan_oh;
  assign reg_valid  = 32'(idx_q) < NUM_REGS;

  // Read response and RX snapshot word.
  always_comb begin
    if (reg_valid)            read_byte = sel_reg;
    else if (stat_valid)      read_byte = stat_byte;
    else if (idx_q == REG_ID) read_byte = ID_VALUE;
    else                      read_byte = 8'h00;
    rx_word                 = '0;
    rx_word[WORD_WIDTH-1:0] = sel_rx_data;
    rx_word[15]             = sel_rx_error;
    rx_word[14]             = sel_rx_empty;
    if (!chan_valid) rx_word = 16'h4000;
  end

  // Command FSM next state and registered-output next values.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    mask_d          = mask_q;
    hi_d            = hi_q;
    word_valid_d    = word_valid_q;
    snap_d          = snap_q;
    control_regs_d  = control_regs_q;
    spi_tx_data_d   = spi_tx_data_q;
    spi_tx_strobe_d = 1'b0;
    tx_data_d       = tx_data_q;
    tx_load_d       = '0;
    tx_reset_d      = '0;
    rx_reset_d      = '0;
    rx_read_d       = '0;
    tx_clear        = '0;
    tx_start_d      = cs_sync_q ? (~tx_empty & ~tx_active) : '0;
    unique case (state_q)
      StIdle: begin
        if (spi_rx_strobe) begin
          idx_d = spi_rx_data[7:4];
          case (spi_rx_data[3:0])
            OP_READ:  state_d = StRd1;
            OP_WRITE: state_d = StWr1;
            OP_TX:    state_d = StTx1;
            OP_RX:    state_d = StRx1;
            OP_RST:   state_d = StRst;
            default:  state_d = StIdle;
          endcase
        end
      end
      StRd1: begin
        spi_tx_data_d   = read_byte;
        spi_tx_strobe_d = 1'b1;
        state_d         = StRd2;
      end
      StRd2: if (spi_rx_strobe) state_d = StRd1;
      StWr1: begin
        if (spi_rx_strobe) begin
          mask_d  = spi_rx_data;
          state_d = StWr2;
        end
      end
      StWr2: begin
        if (spi_rx_strobe) begin
          for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (32'(idx_q) == r) begin
              control_regs_d[8*r +: 8] = (control_regs_q[8*r +: 8] & ~mask_q) |
                                         (spi_rx_data & mask_q);
            end
          end
          state_d = StIdle;
        end
      end
      StTx1: begin
        tx_clear = chan_oh;
        state_d  = StTx2;
      end
      StTx2: begin
        if (spi_rx_strobe) begin
          hi_d            = spi_rx_data[HiW-1:0];
          spi_tx_strobe_d = 1'b1;
          word_valid_d    = 1'b0;
          if (!chan_valid)     spi_tx_data_d = RESP_BAD_CHANNEL;
          else if (sel_full)   spi_tx_data_d = RESP_TX_FULL;
          else if (!sel_ready) spi_tx_data_d = RESP_TX_NOT_READY;
          else begin
            spi_tx_data_d = 8'h00;
            word_valid_d  = 1'b1;
          end
          state_d = StTx3;
        end
      end
      StTx3: begin
        if (spi_rx_strobe) begin
          if (word_valid_q) begin
            tx_data_d = {hi_q, spi_rx_data};
            tx_load_d = chan_oh;
          end
          state_d = StTx2;
        end
      end
      StRx1: begin
        snap_d  = rx_word;
        state_d = StRx2;
      end
      StRx2: begin
        spi_tx_data_d   = snap_q[15:8];
        spi_tx_strobe_d = 1'b1;
        state_d         = StRx3;
      end
      StRx3: begin
        if (spi_rx_strobe) begin
          spi_tx_data_d   = snap_q[7:0];
          spi_tx_strobe_d = 1'b1;
          // Invalid channels have an all-zero one-hot, so no pulse escapes.
          if (snap_q[15])      rx_reset_d = chan_oh;
          else if (!snap_q[14]) rx_read_d = chan_oh;
          state_d = StRx4;
        end
      end
      StRx4: if (spi_rx_strobe) state_d = StRx1;
      StRst: begin
        tx_reset_d = chan_oh;
        rx_reset_d = chan_oh;
        tx_clear   = chan_oh;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A deselected slave always abandons the current command.
    if (cs_sync_q) state_d = StIdle;
  end

  // Chip-select synchroniser; resets to the deselected level.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta_q <= 1'b1;
      cs_sync_q <= 1'b1;
    end else begin
      cs_meta_q <= spi_cs_n;
      cs_sync_q <= cs_meta_q;
    end
  end

  // FSM state and command context.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= 4'h0;
      mask_q       <= 8'h00;
      hi_q         <= '0;
      word_valid_q <= 1'b0;
      snap_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      hi_q         <= hi_d;
      word_valid_q <= word_valid_d;
      snap_q       <= snap_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_tx_data_q   <= 8'h00;
      spi_tx_strobe_q <= 1'b0;
      control_regs_q  <= DEFAULT_REGS;
      tx_data_q       <= '0;
      tx_load_q       <= '0;
      tx_start_q      <= '0;
      tx_reset_q      <= '0;
      rx_reset_q      <= '0;
      rx_read_q       <= '0;
    end else begin
      spi_tx_data_q   <= spi_tx_data_d;
      spi_tx_strobe_q <= spi_tx_strobe_d;
      control_regs_q  <= control_regs_d;
      tx_data_q       <= tx_data_d;
      tx_load_q       <= tx_load_d;
      tx_start_q      <= tx_start_d;
      tx_reset_q      <= tx_reset_d;
      rx_reset_q      <= rx_reset_d;
      rx_read_q       <= rx_read_d;
    end
  end

  assign spi_tx_data     = spi_tx_data_q;
  assign spi_tx_strobe   = spi_tx_strobe_q;
  assign control_regs    = control_regs_q;
  assign tx_data         = tx_data_q;
  assign tx_load_strobe  = tx_load_q;
  assign tx_start_strobe = tx_start_q;
  assign tx_reset        = tx_reset_q;
  assign rx_reset        = rx_reset_q;
  assign rx_read_strobe  = rx_read_q;

endmodule
